uart_tx_fifo: RTL and testbench

// Parametrised, buffered successor to the single-byte UART transmitter in uart_led.

---
 rtl/uart_tx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO_DEPTH-word FIFO feeding an LSB-first serialiser with
// runtime baud, parity and stop-bit selection, all latched per frame.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [2:0]                    baud_select_i,
    input  logic [1:0]                    parity_mode_i,
    input  logic                          two_stop_i,
    input  logic                          tx_en_i,
    input  logic                          tx_wr_i,
    input  logic [DATA_BITS-1:0]          tx_data_i,
    output logic                          txd_o,
    output logic                          tx_busy_o,
    output logic                          fifo_full_o,
    output logic                          fifo_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          tx_ovf_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned DivW = 20;
    localparam int unsigned BitW = 4;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    function automatic logic [DivW-1:0] baud_div(input logic [2:0] sel);
        int unsigned baud;
        case (sel)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        // Rounded to nearest: (a + b/2) / b with b = 16*baud.
        return DivW'((CLK_HZ + 8 * baud) / (16 * baud));
    endfunction

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 full, empty, push, pop;
    logic                 ovf_q;

    // Transmit path
    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0]      div_q, div_cnt_q, div_cnt_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic                 par_q, par_en_q, two_stop_q;
    logic                 txd_q, txd_d;
    logic                 tick, bit_done;

    assign full  = (count_q == CntW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = tx_wr_i && !full;

    assign tick     = (div_cnt_q == div_q - DivW'(1));
    assign bit_done = tick && (tick_cnt_q == 4'hF);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_en_i && !empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (bit_done) begin
                    sh_d = sh_q >> 1;
                    if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
                        state_d   = par_en_q ? StParity : StStop;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    state_d   = StStop;
                    bit_cnt_d = '0;
                end
            end
            StStop: begin
                if (bit_done) begin
                    if (bit_cnt_q == {{(BitW-1){1'b0}}, two_stop_q}) begin
                        if (tx_en_i && !empty) begin
                            pop     = 1'b1;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            sh_d = mem_q[rd_ptr_q];
        end
    end

    // Divider restarts at every frame start so each bit spans exactly 16*DIV clocks.
    always_comb begin
        div_cnt_d  = div_cnt_q + DivW'(1);
        tick_cnt_d = tick_cnt_q;
        if (state_q == StIdle || pop) begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d  = '0;
            tick_cnt_d = tick_cnt_q + 4'd1;
        end
    end

    always_comb begin
        unique case (state_q)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = sh_q[0];
            StParity: txd_d = par_q;
            default:  txd_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            txd_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            txd_q      <= txd_d;
            count_q    <= count_d;
            ovf_q      <= tx_wr_i && full;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PtrW'(1);
                div_q      <= baud_div(baud_select_i);
                par_en_q   <= (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
                par_q      <= (^mem_q[rd_ptr_q]) ^ (parity_mode_i == 2'b10);
                two_stop_q <= two_stop_i;
            end
        end
    end

    assign txd_o        = txd_q;
    assign tx_busy_o    = (state_q != StIdle) || !empty;
    assign fifo_full_o  = full;
    assign fifo_empty_o = empty;
    assign fifo_count_o = count_q;
    assign tx_ovf_o     = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-timeline model checked every cycle, plus directed
// literal expectations for each scenario.
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sel = 3'd7;
    logic [1:0] pmode = 2'b00;
    logic       two = 1'b0;
    logic       en = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] data = 8'h00;
    logic       txd, busy, full, empty, ovf;
    logic [3:0] cnt;

    uart_tx_fifo #(
        .CLK_HZ     (50_000_000),
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .baud_select_i (sel),
        .parity_mode_i (pmode),
        .two_stop_i    (two),
        .tx_en_i       (en),
        .tx_wr_i       (wr),
        .tx_data_i     (data),
        .txd_o         (txd),
        .tx_busy_o     (busy),
        .fifo_full_o   (full),
        .fifo_empty_o  (empty),
        .fifo_count_o  (cnt),
        .tx_ovf_o      (ovf)
    );

    initial forever #5 clk = ~clk;

    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    // Literal expectations posted by the stimulus, checked by the compare process.
    string lit_name [128];
    int    lit_act  [128];
    int    lit_exp  [128];
    int    lit_wr = 0;
    int    lit_rd = 0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_lit(input string nm, input int act, input int exp_v);
        lit_name[lit_wr] = nm;
        lit_act[lit_wr]  = act;
        lit_exp[lit_wr]  = exp_v;
        lit_wr++;
    endtask

    task automatic cmp(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, want %0d", nm, tcyc, act, exp_v);
        end
    endtask

    // Model: a FIFO of words and one active frame described by its start cycle,
    // bit period and bit list; the line shows each bit one clock after the FSM.
    int div_tbl [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};
    int mq[$];
    int m_bits [16];
    int m_nb, m_len, m_start, m_end, m_lvl, nxt, d, ones;
    bit m_act = 0;
    bit m_valid = 0;
    bit m_full;
    int e_txd, e_busy, e_full, e_empty, e_cnt, e_ovf;

    initial begin
        m_lvl = 1;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                cmp("txd", int'(txd), e_txd);
                cmp("busy", int'(busy), e_busy);
                cmp("full", int'(full), e_full);
                cmp("empty", int'(empty), e_empty);
                cmp("count", int'(cnt), e_cnt);
                cmp("ovf", int'(ovf), e_ovf);
            end
            while (lit_rd < lit_wr) begin
                cmp(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
                lit_rd++;
            end
            nxt = tcyc + 1;
            if (rst) begin
                mq.delete();
                m_act   = 0;
                m_lvl   = 1;
                e_txd   = 1;
                e_ovf   = 0;
                m_valid = 1;
            end else if (m_valid) begin
                e_txd  = m_lvl;
                m_full = (mq.size() == DEPTH);
                e_ovf  = (wr && m_full) ? 1 : 0;
                if (m_act && nxt == m_end) m_act = 0;
                if (!m_act && en && mq.size() > 0) begin
                    d     = mq.pop_front();
                    m_len = 16 * div_tbl[sel];
                    m_bits[0] = 0;
                    ones = 0;
                    for (int i = 0; i < 8; i++) begin
                        m_bits[1 + i] = (d >> i) & 1;
                        ones += (d >> i) & 1;
                    end
                    m_nb = 9;
                    if (pmode == 2'b01) begin
                        m_bits[m_nb] = ones & 1;
                        m_nb++;
                    end else if (pmode == 2'b10) begin
                        m_bits[m_nb] = (ones & 1) ^ 1;
                        m_nb++;
                    end
                    m_bits[m_nb] = 1;
                    m_nb++;
                    if (two) begin
                        m_bits[m_nb] = 1;
                        m_nb++;
                    end
                    m_start = nxt;
                    m_end   = nxt + m_nb * m_len;
                    m_act   = 1;
                end
                if (wr && !m_full) mq.push_back(int'(data));
                m_lvl = m_act ? m_bits[(nxt - m_start) / m_len] : 1;
            end
            e_cnt   = mq.size();
            e_busy  = (m_act || e_cnt > 0) ? 1 : 0;
            e_full  = (e_cnt == DEPTH) ? 1 : 0;
            e_empty = (e_cnt == 0) ? 1 : 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int t);
        while (tcyc < t) tick(1);
    endtask

    task automatic push(input logic [7:0] v);
        wr   = 1'b1;
        data = v;
        tick(1);
        wr   = 1'b0;
    endtask

    int t0;
    int lows;
    int t1_bits [10] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 1};

    initial begin
        tick(2);
        expect_lit("rst_txd", int'(txd), 1);
        expect_lit("rst_busy", int'(busy), 0);
        expect_lit("rst_empty", int'(empty), 1);
        expect_lit("rst_full", int'(full), 0);
        expect_lit("rst_count", int'(cnt), 0);
        expect_lit("rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        en  = 1'b1;
        tick(1);

        // 1: 0xA8 8N1 at 115200
        push(8'hA8);
        t0 = tcyc;
        wait_until(t0 + 1);
        expect_lit("t1_idle_before_start", int'(txd), 1);
        wait_until(t0 + 2);
        expect_lit("t1_start_low", int'(txd), 0);
        for (int i = 0; i < 10; i++) begin
            wait_until(t0 + 2 + 432 * i + 216);
            expect_lit("t1_bit", int'(txd), t1_bits[i]);
        end
        wait_until(t0 + 4320);
        expect_lit("t1_busy_last", int'(busy), 1);
        wait_until(t0 + 4321);
        expect_lit("t1_busy_fall", int'(busy), 0);

        // 2: three words, back-to-back frames
        en = 1'b0;
        wr = 1'b1;
        data = 8'h17;
        tick(1);
        data = 8'h55;
        tick(1);
        data = 8'hFF;
        tick(1);
        wr = 1'b0;
        expect_lit("t2_count_peak", int'(cnt), 3);
        en = 1'b1;
        tick(1);
        t0 = tcyc;
        wait_until(t0 + 4320);
        expect_lit("t2_stop1", int'(txd), 1);
        wait_until(t0 + 4321);
        expect_lit("t2_start2", int'(txd), 0);
        wait_until(t0 + 8641);
        expect_lit("t2_start3", int'(txd), 0);
        wait_until(t0 + 12959);
        expect_lit("t2_busy_last", int'(busy), 1);
        wait_until(t0 + 12960);
        expect_lit("t2_busy_fall", int'(busy), 0);

        // 3: overflow while disabled
        en = 1'b0;
        wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data = 8'h31 + 8'(i);
            tick(1);
        end
        expect_lit("t3_full", int'(full), 1);
        expect_lit("t3_count8", int'(cnt), 8);
        data = 8'hC3;
        tick(1);
        wr = 1'b0;
        expect_lit("t3_ovf_pulse", int'(ovf), 1);
        tick(1);
        expect_lit("t3_ovf_clear", int'(ovf), 0);
        expect_lit("t3_still_full", int'(full), 1);
        en = 1'b1;
        tick(1);
        t0 = tcyc;
        wait_until(t0 + 34559);
        expect_lit("t3_busy_8th", int'(busy), 1);
        wait_until(t0 + 34560);
        expect_lit("t3_busy_fall", int'(busy), 0);

        // 4: parity and two stop bits
        pmode = 2'b01;
        push(8'h07);
        t0 = tcyc;
        wait_until(t0 + 2 + 432 * 9 + 216);
        expect_lit("t4_even_par", int'(txd), 1);
        wait_until(t0 + 4753);
        expect_lit("t4_8e1_done", int'(busy), 0);
        pmode = 2'b10;
        two   = 1'b1;
        push(8'h07);
        t0 = tcyc;
        wait_until(t0 + 2 + 432 * 9 + 216);
        expect_lit("t4_odd_par", int'(txd), 0);
        wait_until(t0 + 5184);
        expect_lit("t4_12bit_busy", int'(busy), 1);
        wait_until(t0 + 5185);
        expect_lit("t4_12bit_done", int'(busy), 0);
        pmode = 2'b00;
        two   = 1'b0;

        // 5: baud change mid-frame
        push(8'h01);
        t0 = tcyc;
        push(8'h01);
        wait_until(t0 + 10);
        sel = 3'd6;
        wait_until(t0 + 433);
        expect_lit("t5_f1_start_end", int'(txd), 0);
        wait_until(t0 + 434);
        expect_lit("t5_f1_bit0", int'(txd), 1);
        wait_until(t0 + 4322 + 863);
        expect_lit("t5_f2_start_end", int'(txd), 0);
        wait_until(t0 + 4322 + 864);
        expect_lit("t5_f2_bit0", int'(txd), 1);
        wait_until(t0 + 12962);
        expect_lit("t5_done", int'(busy), 0);
        sel = 3'd7;

        // 6: reset mid-DATA
        push(8'h00);
        t0 = tcyc;
        push(8'h5A);
        wait_until(t0 + 2 + 432 * 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_lit("t6_txd", int'(txd), 1);
        expect_lit("t6_count", int'(cnt), 0);
        expect_lit("t6_busy", int'(busy), 0);
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (txd !== 1'b1) lows++;
        end
        expect_lit("t6_quiet_line", lows, 0);

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
